batch_engine: RTL and testbench
===============================

BATCH_ENGINE -- requirements
Module: batch_engine

Interface
REQ-001 Parameters SHALL be: ELEM_W, 16, element width; BUS_W, 32, stream beat width; ELEMS, 512, elements per batch; TIMEOUT, 65535, max EXEC cycles (0 = no timeout).
REQ-002 Legal parameters SHALL satisfy: BUS_W multiple of ELEM_W; ELEMS multiple of PACK = BUS_W/ELEM_W; BEATS = ELEMS/PACK.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- bus_clk  in  1  sole clock, all logic on rising edge
- rst  in  1  async active-high reset
- enable  in  1  host has both device files open
- s_valid  in  1  input beat available
- s_ready  out  1  block accepts input beat
- s_data  in  BUS_W  input beat
- k_data  out  ELEMS*ELEM_W  captured batch to kernel array, element i at bits [i*ELEM_W +: ELEM_W]
- k_start  out  1  one-cycle kernel start pulse
- k_done  in  1  kernel array results valid
- k_result  in  ELEMS*ELEM_W  kernel array results, same packing as k_data
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts output beat
- m_data  out  BUS_W  output beat
- state  out  4  one-hot state for LEDs
- batch_count  out  16  completed batches
- err_timeout  out  1  sticky EXEC timeout flag

Function
REQ-005 FSM SHALL have states IDLE=0001, RECV=0010, EXEC=0100, SEND=1000, driven on state.
REQ-006 IDLE -> RECV when enable=1; otherwise hold.
REQ-007 In RECV s_ready SHALL be 1; a beat transfers when s_valid&&s_ready.
REQ-008 Beat b SHALL write element b*PACK+j from s_data[j*ELEM_W +: ELEM_W], j=0..PACK-1 (low element first).
REQ-009 Beat counter SHALL count 0..BEATS-1; transfer of beat BEATS-1 SHALL move to EXEC next cycle with counter cleared; no beat beyond BEATS-1 accepted (s_ready=0 outside RECV).
REQ-010 k_start SHALL be 1 exactly in the first EXEC cycle, 0 otherwise.
REQ-011 EXEC SHALL count cycles from 0; k_done=1 in EXEC SHALL capture k_result into the result buffer and move to SEND.
REQ-012 If TIMEOUT!=0 and count reaches TIMEOUT-1 without k_done, block SHALL capture k_result, set err_timeout, move to SEND.
REQ-013 k_done and timeout in the same cycle: k_done wins, err_timeout unchanged.
REQ-014 k_done outside EXEC SHALL be ignored.
REQ-015 In SEND m_valid SHALL be 1; m_data for beat b SHALL pack result elements b*PACK+j as in REQ-008.
REQ-016 While m_valid&&!m_ready, m_data SHALL be held stable; beat advances only on m_valid&&m_ready.
REQ-017 Transfer of beat BEATS-1 SHALL return to IDLE, clear send counter, increment batch_count (wrap 65535 -> 0).
REQ-018 enable=0 in any state SHALL force IDLE next cycle, clear beat/exec counters, deassert s_ready/m_valid/k_start; batch_count, err_timeout, buffers retained; partial batch discarded.
REQ-019 k_data SHALL reflect the input buffer continuously; buffer contents only change on accepted RECV beats.
REQ-020 err_timeout SHALL clear only on rst.

Reset
REQ-021 On rst=1, immediately: state=IDLE (0001), s_ready=0, m_valid=0, m_data=0, k_start=0, batch_count=0, err_timeout=0, all counters 0.
REQ-022 Input and result buffers SHALL NOT require reset; m_data SHALL read 0 until first SEND.
REQ-023 rst assertion mid-batch SHALL abort the batch; after release, block waits in IDLE for enable.

Verification
REQ-024 Normal batch (defaults): enable=1, 256 beats s_data={2i+1,2i}, k_done 10 cycles after k_start, m_ready=1 -> k_data element n = n, 256 output beats = k_result packing, batch_count=1, state back to 0001.
REQ-025 Backpressure: m_ready toggling 1/0 every cycle plus s_valid gaps -> no lost/duplicated beats, m_data stable while stalled, 256 beats out.
REQ-026 Timeout: TIMEOUT=100, k_done never asserted -> SEND entered exactly 100 cycles after EXEC entry, err_timeout=1, 256 beats sent.
REQ-027 Race: k_done asserted in EXEC cycle TIMEOUT-1 -> err_timeout stays 0.
REQ-028 Abort: enable=0 after 100 RECV beats -> IDLE next cycle, s_ready=0; re-enable and full batch -> correct results, batch_count increments once.
REQ-029 Async reset mid-SEND: rst pulse between clock edges -> m_valid=0, state=0001, batch_count=0 before next edge.

Source files
------------

// File: rtl/batch_engine.sv
// ---------------------------------------------------------------------------
// batch_engine
//
// Purpose:
//    Collects one batch of ELEMS elements from an input stream and presents
//    the batch to a kernel array in parallel. It starts the kernel and waits
//    for completion (or a timeout). It then captures the kernel results and
//    streams them back out, BUS_W bits per beat, low element first.
//
// Parameters:
//    ELEM_W   element width
//    BUS_W    stream beat width (a multiple of ELEM_W)
//    ELEMS    elements per batch (a multiple of BUS_W/ELEM_W)
//    TIMEOUT  maximum EXEC cycles, 0 disables the timeout
//
// Ports:
//    bus_clk      sole clock, rising edge
//    rst          asynchronous active-high reset
//    enable       host has both device files open; low forces IDLE
//    s_valid/s_ready/s_data     input stream
//    k_data       captured input batch, element i at [i*ELEM_W +: ELEM_W]
//    k_start      one-cycle kernel start pulse (first EXEC cycle)
//    k_done       kernel results valid (honoured only in EXEC)
//    k_result     kernel results, same packing as k_data
//    m_valid/m_ready/m_data     output stream
//    state        one-hot state: IDLE=0001 RECV=0010 EXEC=0100 SEND=1000
//    batch_count  completed batches, wraps at 16 bits
//    err_timeout  sticky EXEC timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module batch_engine #(
   parameter int unsigned ELEM_W  = 16,
   parameter int unsigned BUS_W   = 32,
   parameter int unsigned ELEMS   = 512,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic                      bus_clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [BUS_W-1:0]          s_data,
   output logic [ELEMS*ELEM_W-1:0]   k_data,
   output logic                      k_start,
   input  logic                      k_done,
   input  logic [ELEMS*ELEM_W-1:0]   k_result,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [BUS_W-1:0]          m_data,
   output logic [3:0]                state,
   output logic [15:0]               batch_count,
   output logic                      err_timeout
);

   localparam int unsigned PACK   = BUS_W / ELEM_W;
   localparam int unsigned BEATS  = ELEMS / PACK;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned EXEC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [EXEC_W-1:0] LAST_EXEC = EXEC_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      RECV = 4'b0010,
      EXEC = 4'b0100,
      SEND = 4'b1000
   } state_t;

   state_t              state_reg;
   logic [BEAT_W-1:0]   beat_cnt_reg;
   logic [EXEC_W-1:0]   exec_cnt_reg;
   logic [BEAT_W-1:0]   send_cnt_reg;
   logic                s_ready_reg;
   logic                m_valid_reg;
   logic [BUS_W-1:0]    m_data_reg;
   logic                k_start_reg;
   logic [15:0]         batch_count_reg;
   logic                err_timeout_reg;

   // Buffers are stored beat-wide: beat b already holds elements
   // b*PACK .. b*PACK+PACK-1 with the lowest element in the low bits, so the
   // flat element packing of k_data/k_result is just the beats laid end to end.
   logic [BUS_W-1:0]    in_buf  [BEATS];
   logic [BUS_W-1:0]    res_buf [BEATS];

   logic                s_fire;
   logic                m_fire;
   logic                timeout_hit;
   logic                capture;
   logic [BEAT_W-1:0]   send_next;

   assign s_fire      = s_valid && s_ready_reg;
   assign m_fire      = m_valid_reg && m_ready;
   assign timeout_hit = (TIMEOUT != 0) && (exec_cnt_reg == LAST_EXEC);
   // k_done has priority over the timeout; both paths capture the results.
   assign capture     = enable && (state_reg == EXEC) && (k_done || timeout_hit);
   assign send_next   = send_cnt_reg + BEAT_W'(1);

   // ------------------------------------------------------------------------
   // Data buffers (no reset needed; contents are qualified by the FSM)
   // ------------------------------------------------------------------------
   always_ff @(posedge bus_clk) begin
      if (s_fire) begin
         in_buf[beat_cnt_reg] <= s_data;
      end
   end

   always_ff @(posedge bus_clk) begin
      if (capture) begin
         for (int b = 0; b < int'(BEATS); b++) begin
            res_buf[b] <= k_result[b*BUS_W +: BUS_W];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < int'(BEATS); gi++) begin : g_kdata
         assign k_data[gi*BUS_W +: BUS_W] = in_buf[gi];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         beat_cnt_reg    <= '0;
         exec_cnt_reg    <= '0;
         send_cnt_reg    <= '0;
         s_ready_reg     <= 1'b0;
         m_valid_reg     <= 1'b0;
         m_data_reg      <= '0;
         k_start_reg     <= 1'b0;
         batch_count_reg <= '0;
         err_timeout_reg <= 1'b0;
      end else begin
         // k_start is a single-cycle pulse; only the RECV->EXEC step raises it.
         k_start_reg <= 1'b0;

         if (!enable) begin
            // Host went away: drop any partial batch, keep stats and buffers.
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            exec_cnt_reg <= '0;
            send_cnt_reg <= '0;
            s_ready_reg  <= 1'b0;
            m_valid_reg  <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg   <= RECV;
                  s_ready_reg <= 1'b1;
               end

               RECV: begin
                  if (s_fire) begin
                     if (beat_cnt_reg == LAST_BEAT) begin
                        state_reg    <= EXEC;
                        beat_cnt_reg <= '0;
                        s_ready_reg  <= 1'b0;
                        k_start_reg  <= 1'b1;
                        exec_cnt_reg <= '0;
                     end else begin
                        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                     end
                  end
               end

               EXEC: begin
                  if (capture) begin
                     state_reg    <= SEND;
                     exec_cnt_reg <= '0;
                     send_cnt_reg <= '0;
                     m_valid_reg  <= 1'b1;
                     // First output beat comes straight from the kernel bus,
                     // as the result buffer is being written on this edge.
                     m_data_reg   <= k_result[BUS_W-1:0];
                     if (!k_done) begin
                        err_timeout_reg <= 1'b1;
                     end
                  end else begin
                     exec_cnt_reg <= exec_cnt_reg + EXEC_W'(1);
                  end
               end

               SEND: begin
                  if (m_fire) begin
                     if (send_cnt_reg == LAST_BEAT) begin
                        state_reg       <= IDLE;
                        send_cnt_reg    <= '0;
                        m_valid_reg     <= 1'b0;
                        batch_count_reg <= batch_count_reg + 16'd1;
                     end else begin
                        send_cnt_reg <= send_next;
                        m_data_reg   <= res_buf[send_next];
                     end
                  end
               end

               default: begin
                  state_reg    <= IDLE;
                  beat_cnt_reg <= '0;
                  exec_cnt_reg <= '0;
                  send_cnt_reg <= '0;
                  s_ready_reg  <= 1'b0;
                  m_valid_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state       = state_reg;
   assign s_ready     = s_ready_reg;
   assign m_valid     = m_valid_reg;
   assign m_data      = m_data_reg;
   assign k_start     = k_start_reg;
   assign batch_count = batch_count_reg;
   assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_batch_engine.sv
// ---------------------------------------------------------------------------
// tb_batch_engine
//
// Purpose:
//    Self-checking bench for batch_engine (TIMEOUT reduced to 100). A table
//    of batch scenarios is run in a loop; abort, idle hold and asynchronous
//    reset mid-SEND are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_batch_engine;

   localparam int ELEM_W  = 16;
   localparam int BUS_W   = 32;
   localparam int ELEMS   = 512;
   localparam int TIMEOUT = 100;
   localparam int BEATS   = ELEMS / (BUS_W / ELEM_W);
   localparam int KW      = ELEMS * ELEM_W;

   logic              bus_clk;
   logic              rst;
   logic              enable;
   logic              s_valid;
   logic              s_ready;
   logic [BUS_W-1:0]  s_data;
   logic [KW-1:0]     k_data;
   logic              k_start;
   logic              k_done;
   logic [KW-1:0]     k_result;
   logic              m_valid;
   logic              m_ready;
   logic [BUS_W-1:0]  m_data;
   logic [3:0]        state;
   logic [15:0]       batch_count;
   logic              err_timeout;

   batch_engine #(
      .ELEM_W  (ELEM_W),
      .BUS_W   (BUS_W),
      .ELEMS   (ELEMS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .bus_clk     (bus_clk),
      .rst         (rst),
      .enable      (enable),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .k_data      (k_data),
      .k_start     (k_start),
      .k_done      (k_done),
      .k_result    (k_result),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .state       (state),
      .batch_count (batch_count),
      .err_timeout (err_timeout)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit s_gaps;      // s_valid drops every third cycle
      bit m_toggle;    // m_ready toggles every cycle
      bit kd_in_recv;  // hold k_done high during RECV (must be ignored)
      int kdelay;      // EXEC cycle in which k_done is raised, -1 = never
      int seed;        // kernel result pattern
      int exp_exec;    // expected EXEC cycles before SEND
      bit exp_err;     // expected err_timeout after the batch
      int exp_count;   // expected batch_count after the batch
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
      else $display("ok   %s = %0h", name, act);
   endtask

   task automatic step();
      @(posedge bus_clk);
      #1;
   endtask

   function automatic logic [BUS_W-1:0] in_word(input int b, input bit abort_data);
      logic [15:0] lo;
      logic [15:0] hi;
      lo = abort_data ? 16'(16'hF000 + 2*b)     : 16'(2*b);
      hi = abort_data ? 16'(16'hF000 + 2*b + 1) : 16'(2*b + 1);
      return {hi, lo};
   endfunction

   function automatic logic [15:0] res_elem(input int n, input int seed);
      return 16'(n*3 + seed);
   endfunction

   function automatic logic [BUS_W-1:0] exp_word(input int b, input int seed);
      return {res_elem(2*b + 1, seed), res_elem(2*b, seed)};
   endfunction

   function automatic logic [KW-1:0] kres(input int seed);
      logic [KW-1:0] r;
      r = '0;
      for (int n = 0; n < ELEMS; n++) r[n*ELEM_W +: ELEM_W] = res_elem(n, seed);
      return r;
   endfunction

   function automatic int kdata_errs();
      int e;
      e = 0;
      for (int n = 0; n < ELEMS; n++)
         if (k_data[n*ELEM_W +: ELEM_W] !== 16'(n)) e++;
      return e;
   endfunction

   // Feed nbeats input beats; returns the number actually transferred.
   task automatic feed(input int nbeats, input bit gaps, input bit abort_data,
                       input bit kd_recv, output int sent);
      int b;
      int cyc;
      bit fire;
      b = 0;
      cyc = 0;
      k_done = kd_recv;
      while (b < nbeats && cyc < 3000) begin
         s_valid = gaps ? (cyc % 3 != 2) : 1'b1;
         s_data  = in_word(b, abort_data);
         fire = s_valid && s_ready;
         step();
         if (fire) b++;
         cyc++;
      end
      s_valid = 1'b0;
      k_done  = 1'b0;
      sent = b;
   endtask

   // Runs EXEC from its first cycle; returns cycles spent before SEND.
   task automatic run_exec(input int kdelay, output int cycles);
      int c;
      c = 0;
      while (state != 4'b1000 && c < 1000) begin
         k_done = (c == kdelay);
         if (c == 1) chk("k_start_second_cycle", 32'(k_start), 32'd0);
         step();
         c++;
      end
      k_done = 1'b0;
      cycles = c;
   endtask

   task automatic drain(input int nbeats, input bit toggle, input int seed, output int got);
      int b;
      int cyc;
      int data_err;
      int valid_err;
      int stab_err;
      bit fire;
      bit stall_prev;
      logic [BUS_W-1:0] prev;
      b = 0;
      cyc = 0;
      data_err = 0;
      valid_err = 0;
      stab_err = 0;
      stall_prev = 1'b0;
      prev = '0;
      while (b < nbeats && cyc < 3000) begin
         m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (m_valid !== 1'b1) valid_err++;
         else if (m_data !== exp_word(b, seed)) data_err++;
         if (stall_prev && m_data !== prev) stab_err++;
         fire = m_valid && m_ready;
         stall_prev = m_valid && !m_ready;
         prev = m_data;
         step();
         if (fire) b++;
         cyc++;
      end
      m_ready = 1'b0;
      got = b;
      chk("send_data_errs", 32'(data_err), 32'd0);
      chk("send_valid_errs", 32'(valid_err), 32'd0);
      chk("send_stable_errs", 32'(stab_err), 32'd0);
   endtask

   task automatic run_batch(input vec_t v, input int idx);
      int sent;
      int cycles;
      int got;
      $display("-- batch %0d kdelay=%0d seed=%0d", idx, v.kdelay, v.seed);
      k_result = kres(v.seed);
      feed(BEATS, v.s_gaps, 1'b0, v.kd_in_recv, sent);
      chk("recv_beats", 32'(sent), 32'(BEATS));
      chk("exec_entry_state", 32'(state), 32'h4);
      chk("k_start_first", 32'(k_start), 32'd1);
      chk("s_ready_exec", 32'(s_ready), 32'd0);
      chk("k_data_errs", 32'(kdata_errs()), 32'd0);
      run_exec(v.kdelay, cycles);
      chk("exec_cycles", 32'(cycles), 32'(v.exp_exec));
      chk("err_timeout", 32'(err_timeout), 32'(v.exp_err));
      drain(BEATS, v.m_toggle, v.seed, got);
      chk("send_beats", 32'(got), 32'(BEATS));
      chk("end_state", 32'(state), 32'h1);
      chk("end_m_valid", 32'(m_valid), 32'd0);
      chk("batch_count", 32'(batch_count), 32'(v.exp_count));
   endtask

   initial begin
      int sent;
      int cycles;
      int got;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 10, 100, 11,  1'b0, 1};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 3,  200, 4,   1'b0, 2};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 99, 300, 100, 1'b0, 3};
      vecs[3] = '{1'b0, 1'b1, 1'b0, -1, 400, 100, 1'b1, 4};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 0,  500, 1,   1'b1, 5};

      rst = 1'b1;
      enable = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      k_done = 1'b0;
      k_result = '0;
      m_ready = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_state", 32'(state), 32'h1);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_k_start", 32'(k_start), 32'd0);
      chk("rst_batch_count", 32'(batch_count), 32'd0);
      chk("rst_err_timeout", 32'(err_timeout), 32'd0);
      rst = 1'b0;

      // IDLE holds without enable; stray k_done is ignored
      k_done = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("idle_hold_state", 32'(state), 32'h1);
      chk("idle_hold_m_valid", 32'(m_valid), 32'd0);
      chk("idle_hold_k_start", 32'(k_start), 32'd0);
      k_done = 1'b0;

      // Abort after 100 beats
      enable = 1'b1;
      feed(100, 1'b0, 1'b1, 1'b0, sent);
      chk("abort_beats", 32'(sent), 32'd100);
      chk("abort_pre_state", 32'(state), 32'h2);
      enable = 1'b0;
      step();
      chk("abort_state", 32'(state), 32'h1);
      chk("abort_s_ready", 32'(s_ready), 32'd0);
      chk("abort_batch_count", 32'(batch_count), 32'd0);
      step();
      enable = 1'b1;

      // Table-driven batches
      for (int i = 0; i < 5; i++) run_batch(vecs[i], i);

      // Asynchronous reset in the middle of SEND
      k_result = kres(600);
      feed(BEATS, 1'b0, 1'b0, 1'b0, sent);
      run_exec(5, cycles);
      chk("ar_exec_cycles", 32'(cycles), 32'd6);
      drain(20, 1'b0, 600, got);
      chk("ar_partial_beats", 32'(got), 32'd20);
      chk("ar_pre_state", 32'(state), 32'h8);
      #2;
      rst = 1'b1;
      enable = 1'b0;
      #1;
      chk("ar_state", 32'(state), 32'h1);
      chk("ar_m_valid", 32'(m_valid), 32'd0);
      chk("ar_batch_count", 32'(batch_count), 32'd0);
      chk("ar_err_timeout", 32'(err_timeout), 32'd0);
      chk("ar_m_data", m_data, 32'd0);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("ar_wait_idle", 32'(state), 32'h1);
      enable = 1'b1;
      step();
      chk("ar_reenable_state", 32'(state), 32'h2);
      chk("ar_reenable_s_ready", 32'(s_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
